// File: rtl/lfsr_checker_if.sv
// Serial-bit and status bundle for the 13-bit LFSR stream checker.
// The master side drives the bit stream. The slave side reports lock and error status.
interface lfsr_checker_if;
    logic        bit_in;
    logic        bit_valid;
    logic        lock;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;

    modport master (output bit_in, bit_valid, input lock, err_pulse, err_count, state);
    modport slave  (input bit_in, bit_valid, output lock, err_pulse, err_count, state);
endinterface

// File: rtl/lfsr_checker.sv
// Locks onto the game LFSR stream s[n] = s[n-1]^s[n-8]^s[n-11]^s[n-12]^s[n-13].
// Once locked, it flywheels on its own prediction and counts the received bits that disagree.
module lfsr_checker #(
    parameter int BITS        = 13,
    parameter int LOCK_THRESH = 16,
    parameter int LOSS_THRESH = 4
) (
    input  logic          clk,
    input  logic          rst,
    lfsr_checker_if.slave bus
);
    localparam int SW = $clog2(BITS + 1);
    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);
    localparam logic [SW-1:0] SEED_LAST = SW'(BITS - 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_THRESH - 1);
    localparam logic [LW-1:0] MISS_LAST = LW'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {SEED = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

    state_t          state_q, state_nx;
    logic [BITS-1:0] h_q, h_nx;
    logic [SW-1:0]   seed_q, seed_nx;
    logic [MW-1:0]   match_q, match_nx;
    logic [LW-1:0]   miss_q, miss_nx;
    logic [15:0]     err_q, err_nx;
    logic            pulse_q, pulse_nx;
    logic            pred, miss;

    // h[0] holds the newest bit, so h[k] corresponds to s[n-1-k].
    assign pred = h_q[12] ^ h_q[11] ^ h_q[10] ^ h_q[7] ^ h_q[0];
    assign miss = bus.bit_in != pred;

    always_comb begin
        state_nx = state_q;
        h_nx     = h_q;
        seed_nx  = seed_q;
        match_nx = match_q;
        miss_nx  = miss_q;
        err_nx   = err_q;
        pulse_nx = 1'b0;
        if (bus.bit_valid) begin
            unique case (state_q)
                SEED: begin
                    h_nx = {h_q[BITS-2:0], bus.bit_in};
                    if (seed_q == SEED_LAST) begin
                        seed_nx = '0;
                        if (h_nx != '0) state_nx = VERIFY;
                    end else begin
                        seed_nx = seed_q + SW'(1);
                    end
                end
                VERIFY: begin
                    h_nx = {h_q[BITS-2:0], bus.bit_in};
                    if (miss) begin
                        match_nx = '0;
                        seed_nx  = '0;
                        state_nx = SEED;
                    end else if (match_q == LOCK_LAST) begin
                        match_nx = '0;
                        state_nx = LOCKED;
                    end else begin
                        match_nx = match_q + MW'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: received bits are judged but never loaded, so errors cannot corrupt h.
                    h_nx = {h_q[BITS-2:0], pred};
                    if (miss) begin
                        pulse_nx = 1'b1;
                        err_nx   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        if (miss_q == MISS_LAST) begin
                            miss_nx  = '0;
                            seed_nx  = '0;
                            state_nx = SEED;
                        end else begin
                            miss_nx = miss_q + LW'(1);
                        end
                    end else begin
                        miss_nx = '0;
                    end
                end
                default: state_nx = SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
            h_q     <= '0;
            seed_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            h_q     <= h_nx;
            seed_q  <= seed_nx;
            match_q <= match_nx;
            miss_q  <= miss_nx;
            err_q   <= err_nx;
            pulse_q <= pulse_nx;
        end
    end

    assign bus.state     = state_q;
    assign bus.lock      = (state_q == LOCKED);
    assign bus.err_pulse = pulse_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: directed scenarios plus random stimulus, scored against a bit-history model.
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_checker_if b0();
    lfsr_checker_if b1();

    lfsr_checker u0 (.clk(clk), .rst(rst), .bus(b0));
    lfsr_checker #(.LOSS_THRESH(1 << 20)) u1 (.clk(clk), .rst(rst), .bus(b1));

    int errors = 0;
    int checks = 0;
    int strm[80000];

    // Model state: 0=SEED, 1=VERIFY, 2=LOCKED. m_h[0] is the oldest bit and m_h[12] is the newest.
    int m_state, m_seed, m_match, m_miss, m_err, m_pulse;
    int m_h[$];
    int pulses, lock_hi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_seed = 0; m_match = 0; m_miss = 0; m_err = 0; m_pulse = 0;
        m_h = {};
        for (int i = 0; i < 13; i++) m_h.push_back(0);
    endtask

    task automatic m_shift(input int b);
        m_h.push_back(b);
        void'(m_h.pop_front());
    endtask

    task automatic m_step(input int b);
        int p, nz;
        p = m_h[12] ^ m_h[5] ^ m_h[2] ^ m_h[1] ^ m_h[0];
        m_pulse = 0;
        case (m_state)
            0: begin
                m_shift(b);
                m_seed++;
                if (m_seed == 13) begin
                    m_seed = 0;
                    nz = 0;
                    foreach (m_h[i]) nz |= m_h[i];
                    if (nz != 0) m_state = 1;
                end
            end
            1: begin
                m_shift(b);
                if (b != p) begin
                    m_match = 0; m_seed = 0; m_state = 0;
                end else begin
                    m_match++;
                    if (m_match == 16) begin m_match = 0; m_state = 2; end
                end
            end
            default: begin
                m_shift(p);
                if (b != p) begin
                    m_pulse = 1;
                    if (m_err < 65535) m_err++;
                    m_miss++;
                    if (m_miss == 4) begin m_miss = 0; m_seed = 0; m_state = 0; end
                end else begin
                    m_miss = 0;
                end
            end
        endcase
    endtask

    // Drive one cycle on u0, advance the model, and compare every output.
    task automatic cyc(input int b, input int v);
        b0.bit_in    = b[0];
        b0.bit_valid = v[0];
        @(posedge clk); #1;
        if (rst) m_reset();
        else if (v != 0) m_step(b[0]);
        else m_pulse = 0;
        chk("state", 32'(b0.state), m_state);
        chk("lock", 32'(b0.lock), (m_state == 2));
        chk("err_pulse", 32'(b0.err_pulse), m_pulse);
        chk("err_count", 32'(b0.err_count), m_err);
        pulses  += (b0.err_pulse === 1'b1);
        lock_hi += (b0.lock === 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
    endtask

    initial begin
        int k, b, v;
        for (int i = 0; i < 80000; i++)
            strm[i] = (i < 13) ? (i == 0) :
                      strm[i-1] ^ strm[i-8] ^ strm[i-11] ^ strm[i-12] ^ strm[i-13];
        b1.bit_in = 1'b0; b1.bit_valid = 1'b0;
        m_reset();
        pulses = 0; lock_hi = 0;

        // Reset values.
        rst = 1'b1;
        cyc(1, 1);
        cyc(0, 0);
        rst = 1'b0;

        // Clean continuous stream: lock on bit 29, with no errors after 1000 bits.
        for (int i = 0; i < 1000; i++) begin
            cyc(strm[i], 1);
            if (i == 27) chk("no_lock_bit28", 32'(b0.lock), 0);
            if (i == 28) chk("lock_bit29", 32'(b0.lock), 1);
        end
        chk("clean_err_count", 32'(b0.err_count), 0);

        // Flip a single bit at locked bit 100, then flip four consecutive bits.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 180; i++) cyc(strm[i] ^ (i == 128), 1);
        chk("single_flip_pulses", pulses, 1);
        chk("single_flip_count", 32'(b0.err_count), 1);
        chk("single_flip_lock", 32'(b0.lock), 1);
        for (int i = 180; i < 184; i++) begin
            cyc(strm[i] ^ 1, 1);
            if (i == 182) chk("lock_held_3miss", 32'(b0.lock), 1);
        end
        chk("four_flip_pulses", pulses, 5);
        chk("four_flip_count", 32'(b0.err_count), 5);
        chk("four_flip_lock", 32'(b0.lock), 0);
        chk("four_flip_state", 32'(b0.state), 0);
        for (int i = 184; i < 240; i++) cyc(strm[i], 1);
        chk("count_held_relock", 32'(b0.err_count), 5);

        // All-zero stream never leaves SEED.
        do_reset();
        lock_hi = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 1);
            chk("zero_state_seed", 32'(b0.state), 0);
        end
        chk("zero_never_lock", lock_hi, 0);

        // bit_valid alternates; idle cycles carry junk data.
        do_reset();
        k = 0;
        for (int c = 0; c < 64; c++) begin
            v = (c % 2 == 0);
            b = v ? strm[k] : int'($urandom_range(1));
            cyc(b, v);
            if (v != 0) k++;
            if (c == 55) chk("toggle_no_lock", 32'(b0.lock), 0);
            if (c == 56) chk("toggle_lock", 32'(b0.lock), 1);
        end

        // Random valid pattern, sparse bit errors, and occasional resets.
        do_reset();
        k = 0;
        for (int c = 0; c < 2500; c++) begin
            v = ($urandom_range(3) != 0);
            b = strm[k] ^ int'($urandom_range(24) == 0);
            rst = ($urandom_range(599) == 0);
            cyc(b, v);
            if (v != 0) k++;
        end
        rst = 1'b0;

        // Reset during VERIFY discards progress; the next bit starts a fresh seed.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(strm[i], 1);
        chk("mid_verify_state", 32'(b0.state), 1);
        rst = 1'b1;
        cyc(strm[20], 1);
        rst = 1'b0;
        chk("rst_state", 32'(b0.state), 0);
        chk("rst_lock", 32'(b0.lock), 0);
        chk("rst_pulse", 32'(b0.err_pulse), 0);
        chk("rst_count", 32'(b0.err_count), 0);
        for (int i = 21; i < 50; i++) begin
            cyc(strm[i], 1);
            if (i == 48) chk("post_rst_no_lock", 32'(b0.lock), 0);
            if (i == 49) chk("post_rst_lock", 32'(b0.lock), 1);
        end
        b0.bit_valid = 1'b0;

        // Saturation: u1 never loses lock, so 70000 inverted bits all count as errors.
        b1.bit_valid = 1'b1;
        for (int i = 0; i < 29; i++) begin
            b1.bit_in = strm[i][0];
            @(posedge clk); #1;
        end
        chk("sat_lock", 32'(b1.lock), 1);
        for (int j = 0; j < 70000; j++) begin
            b1.bit_in = ~strm[29 + j][0];
            @(posedge clk); #1;
            if (j == 65533) chk("sat_fffe", 32'(b1.err_count), 32'hFFFE);
            if (j == 65534) chk("sat_ffff", 32'(b1.err_count), 32'hFFFF);
        end
        b1.bit_valid = 1'b0;
        chk("sat_held", 32'(b1.err_count), 32'hFFFF);
        chk("sat_still_locked", 32'(b1.state), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter BITS, default 13: history register width; the polynomial below is defined only for 13.
REQ-002 Parameter LOCK_THRESH, default 16: consecutive correct predictions needed to declare lock.
REQ-003 Parameter LOSS_THRESH, default 4: consecutive mispredictions while locked that drop lock.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 bit_in  input  1  received serial bit from the 13-bit game LFSR stream.
REQ-007 bit_valid  input  1  bit_in is sampled only in cycles where bit_valid=1.
REQ-008 lock  output  1  high while in state LOCKED.
REQ-009 err_pulse  output  1  one-cycle pulse per mispredicted bit while LOCKED.
REQ-010 err_count  output  16  errors counted while LOCKED, saturating.
REQ-011 state  output  2  current state: SEED=0, VERIFY=1, LOCKED=2.

Function
REQ-012 History h[12:0], h[0] newest; on every accepted bit, h shifts left and the new bit enters h[0].
REQ-013 Prediction pred = h[12]^h[11]^h[10]^h[7]^h[0], i.e. s[n] = s[n-1]^s[n-8]^s[n-11]^s[n-12]^s[n-13].
REQ-014 A cycle with bit_valid=0 changes no state, counter or history; err_pulse=0 in that cycle.
REQ-015 SEED: shifts bit_in into h and counts accepted bits; after the 13th bit, goes to VERIFY if the loaded h != 0, else restarts SEED with count 0.
REQ-016 VERIFY: compares bit_in with pred and shifts bit_in into h; a match increments match_cnt; reaching LOCK_THRESH goes to LOCKED; a mismatch clears match_cnt and seed count and goes to SEED.
REQ-017 LOCKED (flywheel): shifts pred, not bit_in, into h; a match clears miss_cnt.
REQ-018 LOCKED mismatch: err_pulse=1 next cycle, err_count+1, miss_cnt+1.
REQ-019 LOCKED: reaching LOSS_THRESH consecutive misses goes to SEED with seed count 0; err_count is held.
REQ-020 err_count saturates at 16'hFFFF; it never wraps.
REQ-021 All outputs are registered and reflect an accepted bit in the cycle after it is sampled; lock rises in the cycle after the LOCK_THRESH-th match.
REQ-022 The mismatch that causes loss of lock still produces err_pulse and an err_count increment; lock falls in the same cycle.
REQ-023 Continuous bit_valid=1 at full clock rate is supported, with no back-pressure.

Reset
REQ-024 While rst=1 (sampled on clk), the block sets: state=SEED, h=0, all internal counters 0, lock=0, err_pulse=0, err_count=0.
REQ-025 Reset asserted mid-operation in any state takes effect at the next edge, discarding any partial seed or verify progress.
REQ-026 The first bit accepted after rst deasserts is treated as the first seed bit.

Verification
REQ-027 Clean stream, bit_valid=1 continuously: stream from the game LFSR (reset value 13'h0001, output = reg[0]) -> lock=1 one cycle after the 29th bit (13 seed + 16 matches), err_count=0 after 1000 bits.
REQ-028 Single bit flip at locked bit 100 -> exactly one err_pulse, err_count=1, lock stays 1, following bits match.
REQ-029 Four consecutive flipped bits while locked -> four err_pulses, err_count=4, lock falls with the 4th, state=SEED.
REQ-030 All-zero stream -> state never leaves SEED/VERIFY, lock=0; a zero seed restarts SEED every 13 bits.
REQ-031 bit_valid toggling 1/0 on a clean stream -> lock after 29 valid bits (58 cycles), with no extra state change on idle cycles.
REQ-032 Saturation and reset: force 70000 locked errors -> err_count=16'hFFFF held; rst=1 for one cycle mid-VERIFY -> all outputs zero and state=SEED next cycle.
